// File: rtl/multicycle_control_fsm.sv
// +--------------------------------------------------------------------------+
// | multicycle_control_fsm : Moore control FSM for a multicycle RV32 datapath |
// | Optional: MULTICYCLE_ILLEGAL_TRAP_EN (trap on unsupported opcodes)        |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_op,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    IDLE     = STATE_W'(0),
    FETCH    = STATE_W'(1),
    DECODE   = STATE_W'(2),
    MEMADR   = STATE_W'(3),
    MEMREAD  = STATE_W'(4),
    MEMWB    = STATE_W'(5),
    MEMWRITE = STATE_W'(6),
    EXECR    = STATE_W'(7),
    EXECI    = STATE_W'(8),
    ALUWB    = STATE_W'(9),
    JAL      = STATE_W'(10),
    BRANCH   = STATE_W'(11),
    TRAP     = STATE_W'(12)
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;

    case (state)
      IDLE: begin
        state_next = FETCH;
      end

      // PC + 4 goes straight back to the PC through the ALUResult path
      FETCH: begin
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALURES;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        state_next = mem_ready ? DECODE : FETCH;
      end

      DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_JAL:            state_next = JAL;
          OP_BRANCH:         state_next = BRANCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:           state_next = TRAP;
`else
          default:           state_next = FETCH;
`endif
        endcase
      end

      MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_ADD;
        state_next = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end

      MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end

      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = FETCH;
      end

      // Strobe is held until the memory acknowledges the write
      MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        state_next = mem_ready ? FETCH : MEMWRITE;
      end

      EXECR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_FUNCT;
        state_next = ALUWB;
      end

      EXECI: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_FUNCT;
        state_next = ALUWB;
      end

      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = FETCH;
      end

      // Jump target (in ALUOut from DECODE) loads the PC while OldPC + 4 is formed for rd
      JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end

      BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_SUB;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: pc_write = 1'b0;
        endcase
        state_next = FETCH;
      end

      TRAP: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        state_next = TRAP;
`else
        state_next = IDLE;
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  // TRAP is only left through reset, so the flag is sticky by construction
  assign illegal_instr = (state == TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

  assign state_dbg = state;

endmodule

`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style control FSM for the multicycle RV32 datapath.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Drives the select inputs of the datapath's 3-input 32-bit muxes (ALU A/B source, result source), plus the enables for PC, IR, register file and memory.
- Sits directly upstream of those muxes; its 2-bit selects are consumed unchanged.

Parameters:
- STATE_W, 4, width of the state register and of the state_dbg port.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- opcode  input  7  IR[6:0]
- funct3  input  3  IR[14:12]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete this cycle
- pc_write  output  1  PC register load enable
- ir_write  output  1  IR/OldPC load enable
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write strobe
- reg_write  output  1  register file write enable
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register
- alu_src_b  output  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- result_src  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_op  output  2  ALU operation: 00 = add, 01 = sub, 10 = decode by funct
- illegal_instr  output  1  sticky illegal-opcode flag (optional feature only)
- state_dbg  output  STATE_W  current state encoding

Behaviour:
- Reset: asynchronous, active-low.
  - While resetn = 0: state = IDLE and every output is 0.
  - Reset asserted mid-instruction aborts it immediately; no partial write survives past that edge.
- Output decode: all outputs are combinational from state only, except where a line below gates an output with mem_ready, zero or funct3. Fields not listed for a state are 0.
- State encodings, fixed for state_dbg:
  - IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMREAD = 4, MEMWB = 5, MEMWRITE = 6
  - EXECR = 7, EXECI = 8, ALUWB = 9, JAL = 10, BRANCH = 11, TRAP = 12
- IDLE: all outputs 0 -> FETCH unconditionally on the next edge.
- FETCH:
  - Outputs: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - pc_write = ir_write = mem_ready.
  - Stays in FETCH while mem_ready = 0; -> DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - any other opcode -> illegal handling (see Optional Feature).
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00 -> MEMREAD if opcode = 0000011, else MEMWRITE.
- MEMREAD: adr_src = 1, result_src = 00. Waits for mem_ready = 1 -> MEMWB.
- MEMWB: result_src = 01, reg_write = 1 -> FETCH.
- MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1. mem_write is held every cycle until mem_ready = 1 -> FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10 -> ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10 -> ALUWB.
- ALUWB: result_src = 00, reg_write = 1 -> FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_write = 1 -> ALUWB (rd = OldPC + 4).
- BRANCH: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00 -> FETCH.
  - funct3 = 000: pc_write = zero.
  - funct3 = 001: pc_write = ~zero.
  - other funct3: pc_write = 0 (branch not taken).
- Cycle counts, with mem_ready = 1 throughout:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-type ALU, jal: 4 cycles
  - branch: 3 cycles
- Each mem_ready = 0 cycle spent in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- At most one of reg_write, mem_write is asserted in any cycle.
- alu_src_a, alu_src_b and result_src never output 11.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN
- Defined:
  - An unsupported opcode in DECODE -> TRAP.
  - TRAP drives all outputs 0, sets illegal_instr = 1, and stays in TRAP until reset.
  - illegal_instr clears only on reset.
- Undefined:
  - An unsupported opcode in DECODE -> FETCH with no writes (executes as a NOP).
  - TRAP is unreachable; illegal_instr is tied to 0.

Test Plan:
- Reset: hold resetn = 0 for 3 cycles, then release -> state_dbg 0 then 1, all outputs 0 while in reset.
- lw (opcode 0000011) with mem_ready stuck at 0 for 2 cycles in MEMREAD -> state_dbg 1,2,3,4,4,4,5,1; reg_write = 1 only in state 5 with result_src = 01.
- sw (opcode 0100011) with mem_ready low for 1 cycle -> mem_write = 1 for 2 consecutive cycles with adr_src = 1, then back to FETCH; reg_write never asserted.
- Branches:
  - beq (funct3 = 000), zero = 1 -> pc_write = 1 in BRANCH, alu_op = 01.
  - bne (funct3 = 001), zero = 1 -> pc_write = 0.
- jal (1101111) -> state_dbg 2,10,9,1; pc_write = 1 in JAL; reg_write = 1 in ALUWB.
- Opcode 0110111, then resetn pulsed low -> with the macro: state 12 and illegal_instr = 1 until reset clears both; without the macro: DECODE -> FETCH with no writes. An R-type (0110011) sequence run afterwards completes 2,7,9,1.
